bilinear_step_gen: RTL and testbench

//  Upstream stage of the bilinear coefficient ROM in the horizontal scaler.
//  For each output pixel of a line it generates the source pixel pair (x0,x1) and
//  the quantised phase dx that addresses the coefficient ROM.

---
 rtl/bilinear_step_gen.sv | 129 ++++++++++++
 tb/tb_bilinear_step_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bilinear_step_gen.sv
// rtl/bilinear_step_gen.sv - per-output-pixel source pair and phase generator for the bilinear scaler
module bilinear_step_gen #(
   parameter int STEP   = 4096,
   parameter int IDX_W  = 12,
   localparam int FRAC_W = $clog2(STEP),
   localparam int DX_W   = $clog2(STEP / 4),
   localparam int ACC_W  = IDX_W + FRAC_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ACC_W-1:0] cfg_step,
   input  logic [IDX_W-1:0] cfg_src_w,
   input  logic [IDX_W-1:0] cfg_dst_w,
   output logic             busy,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [IDX_W-1:0] o_x0,
   output logic [IDX_W-1:0] o_x1,
   output logic [DX_W-1:0]  o_dx,
   output logic             o_last,
   output logic             done
);

   localparam int P_W = ACC_W - FRAC_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [ACC_W-1:0] acc, step_r;
   logic [IDX_W-1:0] cnt, src_w_r, dst_w_r;
   logic             hs;

   logic [ACC_W-1:0] sel_acc;
   logic [IDX_W-1:0] sel_src;
   logic [P_W-1:0]   p;
   logic [IDX_W-1:0] x0_n, x1_n, cnt_inc;
   logic [DX_W-1:0]  dx_n;
   logic             last_n;
   logic             unused_acc_lsb;

   assign hs             = o_valid & o_ready;
   assign cnt_inc        = cnt + IDX_W'(1);
   assign unused_acc_lsb = ^sel_acc[1:0];

   // State register; reset wins in every state and aborts a line silently
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state: start begins a line (empty lines go straight to FIN), last handshake ends it
   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (start) state_n = (cfg_dst_w != '0) ? RUN : FIN;
         RUN:  if (hs && (cnt == dst_w_r - IDX_W'(1))) state_n = FIN;
         FIN:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Descriptor for the position about to be loaded: 0 at line start, acc+step on a handshake
   always_comb begin
      sel_acc = acc + step_r;
      sel_src = src_w_r;
      last_n  = (cnt_inc == dst_w_r - IDX_W'(1));
      if (state == IDLE) begin
         sel_acc = '0;
         sel_src = cfg_src_w;
         last_n  = (cfg_dst_w == IDX_W'(1));
      end
      p    = sel_acc[ACC_W-1:FRAC_W];
      x0_n = sel_src - IDX_W'(1);
      x1_n = sel_src - IDX_W'(1);
      dx_n = '0;
      // interior: p+1 < src_w; otherwise clamp to the right edge with zero phase
      if (({1'b0, p} + (P_W+1)'(1)) < {2'b00, sel_src}) begin
         x0_n = p[IDX_W-1:0];
         x1_n = p[IDX_W-1:0] + IDX_W'(1);
         dx_n = sel_acc[FRAC_W-1:2];
      end
   end

   // Registered outputs and line datapath; descriptor only changes on start or handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         o_valid <= 1'b0;
         o_last  <= 1'b0;
         o_x0    <= '0;
         o_x1    <= '0;
         o_dx    <= '0;
         acc     <= '0;
         cnt     <= '0;
         step_r  <= '0;
         src_w_r <= '0;
         dst_w_r <= '0;
      end else begin
         busy    <= (state_n != IDLE);
         done    <= (state_n == FIN);
         o_valid <= (state_n == RUN);
         if (state == IDLE && start) begin
            step_r  <= cfg_step;
            src_w_r <= cfg_src_w;
            dst_w_r <= cfg_dst_w;
            acc     <= '0;
            cnt     <= '0;
            o_x0    <= x0_n;
            o_x1    <= x1_n;
            o_dx    <= dx_n;
            o_last  <= last_n;
         end else if (state == RUN && hs) begin
            acc     <= sel_acc;
            cnt     <= cnt_inc;
            o_x0    <= x0_n;
            o_x1    <= x1_n;
            o_dx    <= dx_n;
            o_last  <= last_n && (state_n == RUN);
         end
      end
   end

endmodule

// File: tb/tb_bilinear_step_gen.sv
// tb/tb_bilinear_step_gen.sv - self-checking bench for bilinear_step_gen
module tb_bilinear_step_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [24:0] cfg_step;
   logic [11:0] cfg_src_w;
   logic [11:0] cfg_dst_w;
   logic        busy;
   logic        o_valid;
   logic        o_ready;
   logic [11:0] o_x0;
   logic [11:0] o_x1;
   logic [9:0]  o_dx;
   logic        o_last;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;

   bilinear_step_gen dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_step  (cfg_step),
      .cfg_src_w (cfg_src_w),
      .cfg_dst_w (cfg_dst_w),
      .busy      (busy),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_x0      (o_x0),
      .o_x1      (o_x1),
      .o_dx      (o_dx),
      .o_last    (o_last),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: position i*step (mod 2^25), split into integer pixel and phase
   task automatic ref_desc(input int i, input int src, input int stp,
                           output int x0, output int x1, output int dx);
      longint pos;
      longint pix;
      pos = (longint'(i) * longint'(stp)) % (longint'(1) << 25);
      pix = pos / 4096;
      if (pix < longint'(src - 1)) begin
         x0 = int'(pix);
         x1 = int'(pix) + 1;
         dx = int'((pos % 4096) / 4);
      end else begin
         x0 = src - 1;
         x1 = src - 1;
         dx = 0;
      end
   endtask

   // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready
   task automatic run_line(input int src, input int dst, input int stp, input int mode,
                           input int abort_n, input bit bogus);
      int idx = 0;
      int cyc = 0;
      bit stalled = 1'b0;
      logic [34:0] held = '0;
      int ex0, ex1, edx;
      bit rdy;
      @(negedge clk);
      start = 1'b1; cfg_src_w = 12'(src); cfg_dst_w = 12'(dst); cfg_step = 25'(stp); o_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cfg_src_w = 12'($urandom); cfg_dst_w = 12'($urandom); cfg_step = 25'($urandom);
      if (dst == 0) begin
         chk("empty_valid", 64'(o_valid), 64'd0);
         chk("empty_done", 64'(done), 64'd1);
         @(negedge clk);
         chk("empty_done_pulse", 64'(done), 64'd0);
         chk("empty_busy", 64'(busy), 64'd0);
         return;
      end
      while (idx < dst && cyc < 2000) begin
         chk("busy_run", 64'(busy), 64'd1);
         chk("valid_run", 64'(o_valid), 64'd1);
         chk("no_early_done", 64'(done), 64'd0);
         if (stalled) chk("hold", 64'({o_x0, o_x1, o_dx, o_last}), 64'(held));
         if (bogus && cyc == 2) begin
            start = 1'b1; cfg_src_w = 12'd9; cfg_dst_w = 12'd5; cfg_step = 25'd777;
         end else begin
            start = 1'b0;
         end
         case (mode)
            0: rdy = 1'b1;
            1: rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         o_ready = rdy;
         if (rdy) begin
            ref_desc(idx, src, stp, ex0, ex1, edx);
            chk("x0", 64'(o_x0), 64'(ex0));
            chk("x1", 64'(o_x1), 64'(ex1));
            chk("dx", 64'(o_dx), 64'(edx));
            chk("last", 64'(o_last), 64'(idx == dst - 1));
            idx++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held = {o_x0, o_x1, o_dx, o_last};
         end
         cyc++;
         @(negedge clk);
         if (abort_n >= 0 && idx == abort_n) begin
            rst = 1'b1; o_ready = 1'b0; start = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_valid", 64'(o_valid), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_done", 64'(done), 64'd0);
            @(negedge clk);
            chk("abort_no_done", 64'(done), 64'd0);
            return;
         end
      end
      start = 1'b0;
      o_ready = 1'b0;
      chk("line_timeout", 64'(idx), 64'(dst));
      chk("fin_done", 64'(done), 64'd1);
      chk("fin_valid", 64'(o_valid), 64'd0);
      chk("fin_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_valid", 64'(o_valid), 64'd0);
   endtask

   initial begin
      int s, d;
      rst = 1'b1; start = 1'b0; o_ready = 1'b0;
      cfg_step = '0; cfg_src_w = '0; cfg_dst_w = '0;
      repeat (3) @(negedge clk);
      chk("rst_state", 64'({busy, o_valid, o_last, done, o_x0, o_x1, o_dx}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_no_start", 64'({busy, o_valid, done}), 64'd0);

      run_line(4, 8, 2048, 0, -1, 1'b0);
      run_line(8, 4, 8192, 0, -1, 1'b0);
      run_line(4, 8, 2048, 1, -1, 1'b0);
      run_line(4, 0, 2048, 0, -1, 1'b0);
      run_line(1, 3, 1365, 0, -1, 1'b0);
      run_line(4, 8, 2048, 0, 3, 1'b0);
      run_line(4, 8, 2048, 0, -1, 1'b0);
      run_line(4, 8, 2048, 2, -1, 1'b1);
      run_line(5, 1, 4096, 0, -1, 1'b0);

      for (int t = 0; t < 12; t++) begin
         s = int'($urandom_range(2, 40));
         d = int'($urandom_range(1, 40));
         run_line(s, d, (4096 * s) / d, int'($urandom_range(0, 2)), -1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
